// File: rtl/cr_axis_framer_pkg.sv
// Shared definitions for the CCE inbound AXI-Stream job framer.
//   - tuser codes carried on the output stream (start/end-of-transfer tags)
//   - FSM state encoding of the framer
//   - default-width layout of one header/trailer table entry
//   - helper to bound a per-job entry count by the table depth
package cr_axis_framer_pkg;

    localparam logic [7:0] TUSER_MID     = 8'd0;
    localparam logic [7:0] TUSER_SOT     = 8'd1;
    localparam logic [7:0] TUSER_EOT     = 8'd2;
    localparam logic [7:0] TUSER_SOT_EOT = 8'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_TRL  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // Entry layout at the default widths; the framer packs entries in the
    // same field order {data, user, strb, last} at its parameterised widths.
    localparam int ENTRY_DATA_W = 64;
    localparam int ENTRY_USER_W = 8;
    localparam int ENTRY_STRB_W = ENTRY_DATA_W / 8;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_USER_W-1:0] user;
        logic [ENTRY_STRB_W-1:0] strb;
        logic                    last;
    } entry_t;

    // Entry counts above the table depth would walk past the table and never
    // hit the phase-end compare, so they are saturated at the depth.
    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned depth);
        return (cnt > depth) ? depth : cnt;
    endfunction

endpackage

// File: rtl/cr_axis_framer_tbl.sv
// Small register file holding header or trailer entries.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears all entries)
//   i_we, i_waddr, i_wdata : single write port; addresses >= DEPTH are dropped
//   i_raddr, o_rdata       : combinational read port; out-of-range reads give 0
module cr_axis_framer_tbl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Decoded per entry so an address that does not map to an entry simply
    // matches nothing, rather than aliasing onto a lower entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_we && (i_waddr == IDX_W'(i))) r_mem[i] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == IDX_W'(i)) o_rdata = r_mem[i];
        end
    end

endmodule

// File: rtl/cr_axis_job_framer.sv
// AXI-Stream job framer: per job emits cfg_hdr_cnt header entries, job_len
// payload bytes (generated strobes, EoT tag on the final beat), then
// cfg_trl_cnt trailer entries, all tagged with the job's tid.
//   cfg_*          : header/trailer table writes (IDLE only) and per-job counts
//   job_*          : start pulse with length/tid, sampled in IDLE
//   pl_*           : payload input stream
//   ob_*           : output stream, single registered stage
//   busy/done/err  : status; byte_cnt counts payload bytes of current/last job
//   dbg_state      : current FSM state
//
// Handshakes (pl_* and ob_*): a beat transfers on a rising edge where valid
// and ready are both high. ob_tvalid never depends on ob_tready, and while
// ob_tvalid && !ob_tready all ob_* hold. pl_tready is high only in PAY with
// room in the output stage; pl_tvalid may be raised and dropped freely.
module cr_axis_job_framer
    import cr_axis_framer_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int STRB_W    = DATA_W / 8,
    parameter int USER_W    = 8,
    parameter int TID_W     = 1,
    parameter int HDR_DEPTH = 8,
    parameter int TRL_DEPTH = 4,
    localparam int IDX_W    = $clog2((HDR_DEPTH > TRL_DEPTH) ? HDR_DEPTH : TRL_DEPTH),
    localparam int HCNT_W   = $clog2(HDR_DEPTH + 1),
    localparam int TCNT_W   = $clog2(TRL_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [USER_W-1:0] cfg_user,
    input  logic [STRB_W-1:0] cfg_strb,
    input  logic              cfg_last,
    input  logic [HCNT_W-1:0] cfg_hdr_cnt,
    input  logic [TCNT_W-1:0] cfg_trl_cnt,
    input  logic              job_start,
    input  logic [31:0]       job_len,
    input  logic [TID_W-1:0]  job_tid,
    input  logic              pl_tvalid,
    output logic              pl_tready,
    input  logic [DATA_W-1:0] pl_tdata,
    output logic              ob_tvalid,
    input  logic              ob_tready,
    output logic [DATA_W-1:0] ob_tdata,
    output logic [STRB_W-1:0] ob_tstrb,
    output logic [USER_W-1:0] ob_tuser,
    output logic              ob_tlast,
    output logic [TID_W-1:0]  ob_tid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       byte_cnt,
    output logic [2:0]        dbg_state
);

    localparam int ENT_W = DATA_W + USER_W + STRB_W + 1;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [31:0]        r_rem, w_rem_nxt;
    logic [31:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [TID_W-1:0]   r_tid;
    logic [HCNT_W-1:0]  r_hdr_cnt;
    logic [TCNT_W-1:0]  r_trl_cnt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic               r_ob_tvalid, r_ob_tlast;
    logic [DATA_W-1:0]  r_ob_tdata;
    logic [STRB_W-1:0]  r_ob_tstrb;
    logic [USER_W-1:0]  r_ob_tuser;
    logic [TID_W-1:0]   r_ob_tid;

    logic               w_beat_valid, w_beat_last;
    logic [DATA_W-1:0]  w_beat_data;
    logic [STRB_W-1:0]  w_beat_strb;
    logic [USER_W-1:0]  w_beat_user;

    logic               w_load, w_busy, w_start, w_hdr_end, w_trl_end, w_pay_eot;
    logic [31:0]        w_pay_n;
    logic [STRB_W-1:0]  w_pay_strb;
    logic [HCNT_W-1:0]  w_hdr_cnt_in;
    logic [TCNT_W-1:0]  w_trl_cnt_in;

    logic [ENT_W-1:0]   w_cfg_ent, w_hdr_ent, w_trl_ent;
    logic [DATA_W-1:0]  w_hdr_data, w_trl_data;
    logic [USER_W-1:0]  w_hdr_user, w_trl_user;
    logic [STRB_W-1:0]  w_hdr_strb, w_trl_strb;
    logic               w_hdr_last, w_trl_last;

    assign w_busy    = (r_state != S_IDLE);
    assign w_start   = (r_state == S_IDLE) && job_start;
    // Output stage can take a new beat when empty or being drained this edge.
    assign w_load    = !r_ob_tvalid || ob_tready;
    assign w_cfg_ent = {cfg_data, cfg_user, cfg_strb, cfg_last};
    assign {w_hdr_data, w_hdr_user, w_hdr_strb, w_hdr_last} = w_hdr_ent;
    assign {w_trl_data, w_trl_user, w_trl_strb, w_trl_last} = w_trl_ent;

    assign w_hdr_cnt_in = HCNT_W'(clamp_cnt(32'(cfg_hdr_cnt), HDR_DEPTH));
    assign w_trl_cnt_in = TCNT_W'(clamp_cnt(32'(cfg_trl_cnt), TRL_DEPTH));
    assign w_hdr_end    = (32'(r_idx) + 32'd1) >= 32'(r_hdr_cnt);
    assign w_trl_end    = (32'(r_idx) + 32'd1) >= 32'(r_trl_cnt);
    assign w_pay_eot    = (r_rem <= 32'(STRB_W));
    assign w_pay_n      = w_pay_eot ? r_rem : 32'(STRB_W);

    // Byte b is live while more than b bytes remain: gives (1<<n)-1.
    always_comb begin
        w_pay_strb = '0;
        for (int b = 0; b < STRB_W; b++) w_pay_strb[b] = (r_rem > 32'(b));
    end

    cr_axis_framer_tbl #(.DEPTH(HDR_DEPTH), .WIDTH(ENT_W), .IDX_W(IDX_W)) u_hdr_tbl (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (cfg_we && !w_busy && !cfg_sel),
        .i_waddr (cfg_idx),
        .i_wdata (w_cfg_ent),
        .i_raddr (r_idx),
        .o_rdata (w_hdr_ent)
    );

    cr_axis_framer_tbl #(.DEPTH(TRL_DEPTH), .WIDTH(ENT_W), .IDX_W(IDX_W)) u_trl_tbl (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (cfg_we && !w_busy && cfg_sel),
        .i_waddr (cfg_idx),
        .i_wdata (w_cfg_ent),
        .i_raddr (r_idx),
        .o_rdata (w_trl_ent)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_rem_nxt      = r_rem;
        w_byte_cnt_nxt = r_byte_cnt;
        w_beat_valid   = 1'b0;
        w_beat_data    = '0;
        w_beat_user    = '0;
        w_beat_strb    = '0;
        w_beat_last    = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = w_busy && (job_start || cfg_we);
        unique case (r_state)
            S_IDLE: begin
                if (job_start) begin
                    w_rem_nxt      = job_len;
                    w_byte_cnt_nxt = '0;
                    w_idx_nxt      = '0;
                    if (cfg_hdr_cnt != '0)      w_state_nxt = S_HDR;
                    else if (job_len != 32'd0)  w_state_nxt = S_PAY;
                    else if (cfg_trl_cnt != '0) w_state_nxt = S_TRL;
                    else                        w_state_nxt = S_FIN;
                end
            end
            S_HDR: begin
                if (w_load) begin
                    w_beat_valid = 1'b1;
                    w_beat_data  = w_hdr_data;
                    w_beat_user  = w_hdr_user;
                    w_beat_strb  = w_hdr_strb;
                    w_beat_last  = w_hdr_last;
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    if (w_hdr_end) begin
                        w_idx_nxt = '0;
                        if (r_rem != 32'd0)       w_state_nxt = S_PAY;
                        else if (r_trl_cnt != '0) w_state_nxt = S_TRL;
                        else                      w_state_nxt = S_FIN;
                    end
                end
            end
            S_PAY: begin
                if (w_load && pl_tvalid) begin
                    w_beat_valid   = 1'b1;
                    w_beat_data    = pl_tdata;
                    w_beat_strb    = w_pay_strb;
                    w_beat_user    = w_pay_eot ? USER_W'(TUSER_EOT) : USER_W'(TUSER_MID);
                    w_rem_nxt      = r_rem - w_pay_n;
                    w_byte_cnt_nxt = r_byte_cnt + w_pay_n;
                    if (w_pay_eot) w_state_nxt = (r_trl_cnt != '0) ? S_TRL : S_FIN;
                end
            end
            S_TRL: begin
                if (w_load) begin
                    w_beat_valid = 1'b1;
                    w_beat_data  = w_trl_data;
                    w_beat_user  = w_trl_user;
                    w_beat_strb  = w_trl_strb;
                    w_beat_last  = w_trl_last;
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    if (w_trl_end) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIN: begin
                // Wait here until the last beat has left the output stage.
                if (w_load) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_byte_cnt  <= '0;
            r_tid       <= '0;
            r_hdr_cnt   <= '0;
            r_trl_cnt   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ob_tvalid <= 1'b0;
            r_ob_tdata  <= '0;
            r_ob_tstrb  <= '0;
            r_ob_tuser  <= '0;
            r_ob_tlast  <= 1'b0;
            r_ob_tid    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rem      <= w_rem_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            if (w_start) begin
                r_tid     <= job_tid;
                r_hdr_cnt <= w_hdr_cnt_in;
                r_trl_cnt <= w_trl_cnt_in;
            end
            if (w_load) begin
                r_ob_tvalid <= w_beat_valid;
                r_ob_tdata  <= w_beat_data;
                r_ob_tstrb  <= w_beat_strb;
                r_ob_tuser  <= w_beat_user;
                r_ob_tlast  <= w_beat_last;
                r_ob_tid    <= w_beat_valid ? r_tid : '0;
            end
        end
    end

    assign pl_tready = (r_state == S_PAY) && w_load;
    assign ob_tvalid = r_ob_tvalid;
    assign ob_tdata  = r_ob_tdata;
    assign ob_tstrb  = r_ob_tstrb;
    assign ob_tuser  = r_ob_tuser;
    assign ob_tlast  = r_ob_tlast;
    assign ob_tid    = r_ob_tid;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign byte_cnt  = r_byte_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cr_axis_job_framer.sv
module tb_cr_axis_job_framer;

  localparam int DATA_W    = 64;
  localparam int STRB_W    = 8;
  localparam int USER_W    = 8;
  localparam int TID_W     = 1;
  localparam int HDR_DEPTH = 8;
  localparam int TRL_DEPTH = 4;
  localparam int IDX_W     = 3;
  localparam int HCNT_W    = 4;
  localparam int TCNT_W    = 3;
  localparam int BW        = DATA_W + STRB_W + USER_W + 1 + TID_W;

  logic              clk, rst_n;
  logic              cfg_we, cfg_sel, cfg_last;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_data;
  logic [USER_W-1:0] cfg_user;
  logic [STRB_W-1:0] cfg_strb;
  logic [HCNT_W-1:0] cfg_hdr_cnt;
  logic [TCNT_W-1:0] cfg_trl_cnt;
  logic              job_start;
  logic [31:0]       job_len;
  logic [TID_W-1:0]  job_tid;
  logic              pl_tvalid, pl_tready;
  logic [DATA_W-1:0] pl_tdata;
  logic              ob_tvalid, ob_tready, ob_tlast;
  logic [DATA_W-1:0] ob_tdata;
  logic [STRB_W-1:0] ob_tstrb;
  logic [USER_W-1:0] ob_tuser;
  logic [TID_W-1:0]  ob_tid;
  logic              busy, done, err;
  logic [31:0]       byte_cnt;
  logic [2:0]        dbg_state;

  cr_axis_job_framer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_user(cfg_user), .cfg_strb(cfg_strb), .cfg_last(cfg_last),
    .cfg_hdr_cnt(cfg_hdr_cnt), .cfg_trl_cnt(cfg_trl_cnt),
    .job_start(job_start), .job_len(job_len), .job_tid(job_tid),
    .pl_tvalid(pl_tvalid), .pl_tready(pl_tready), .pl_tdata(pl_tdata),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
    .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  // reference copy of the tables
  logic [DATA_W-1:0] hdr_d[HDR_DEPTH];
  logic [USER_W-1:0] hdr_u[HDR_DEPTH];
  logic [STRB_W-1:0] hdr_s[HDR_DEPTH];
  logic              hdr_l[HDR_DEPTH];
  logic [DATA_W-1:0] trl_d[TRL_DEPTH];
  logic [USER_W-1:0] trl_u[TRL_DEPTH];
  logic [STRB_W-1:0] trl_s[TRL_DEPTH];
  logic              trl_l[TRL_DEPTH];

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < HDR_DEPTH; i++) begin
      hdr_d[i] = '0; hdr_u[i] = '0; hdr_s[i] = '0; hdr_l[i] = 1'b0;
    end
    for (int i = 0; i < TRL_DEPTH; i++) begin
      trl_d[i] = '0; trl_u[i] = '0; trl_s[i] = '0; trl_l[i] = 1'b0;
    end
  endtask

  // driver: one table write, mirrored into the model when the index exists
  task automatic cfg_write(input logic sel, input int idx, input logic [DATA_W-1:0] d,
                           input logic [USER_W-1:0] u, input logic [STRB_W-1:0] s, input logic l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = IDX_W'(idx);
    cfg_data = d; cfg_user = u; cfg_strb = s; cfg_last = l;
    if (!sel && idx < HDR_DEPTH) begin
      hdr_d[idx] = d; hdr_u[idx] = u; hdr_s[idx] = s; hdr_l[idx] = l;
    end
    if (sel && idx < TRL_DEPTH) begin
      trl_d[idx] = d; trl_u[idx] = u; trl_s[idx] = s; trl_l[idx] = l;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    #1 chk("cfg_err", BW'(err), BW'(0));
  endtask

  task automatic load_tables();
    for (int i = 0; i < HDR_DEPTH; i++)
      cfg_write(1'b0, i, {$urandom, $urandom}, 8'h01, 8'hff, 1'b0);
    cfg_write(1'b1, 0, {$urandom, $urandom}, 8'h00, 8'(($urandom_range(1, 255))), 1'b0);
    cfg_write(1'b1, 1, {$urandom, $urandom}, 8'h00, 8'hff, 1'b1);
    cfg_write(1'b1, 2, {$urandom, $urandom}, 8'h00, 8'h0f, 1'b0);
    cfg_write(1'b1, 3, {$urandom, $urandom}, 8'h00, 8'h3f, 1'b1);
    // index beyond the trailer table: must not land on any entry
    cfg_write(1'b1, 5, {$urandom, $urandom}, 8'h55, 8'h55, 1'b0);
  endtask

  // driver + monitor for one job
  task automatic run_job(input int len, input logic [TID_W-1:0] tid, input int hcnt, input int tcnt,
                         input bit rdy_rand, input bit gap_rand, input bit inj_err, input bit inj_rst);
    logic [DATA_W-1:0] pl_data[$];
    logic [BW-1:0] cur, prev;
    int nbeats, hc, tc, cyc, pl_ptr, acc, busy_cyc, first_v, err_n, inj_st;
    bit finished, stalled;
    nbeats = (len + STRB_W - 1) / STRB_W;
    hc = (hcnt > HDR_DEPTH) ? HDR_DEPTH : hcnt;
    tc = (tcnt > TRL_DEPTH) ? TRL_DEPTH : tcnt;
    exp_q.delete();
    for (int i = 0; i < hc; i++) exp_q.push_back({hdr_d[i], hdr_s[i], hdr_u[i], hdr_l[i], tid});
    for (int i = 0; i < nbeats; i++) begin
      logic [DATA_W-1:0] d;
      logic [8:0] m;
      int left, n;
      d = {$urandom, $urandom};
      pl_data.push_back(d);
      left = len - STRB_W * i;
      n = (left < STRB_W) ? left : STRB_W;
      m = (9'd1 << n) - 9'd1;
      exp_q.push_back({d, m[7:0], (left <= STRB_W) ? 8'd2 : 8'd0, 1'b0, tid});
    end
    for (int i = 0; i < tc; i++) exp_q.push_back({trl_d[i], trl_s[i], trl_u[i], trl_l[i], tid});

    @(negedge clk);
    job_start = 1'b1; job_len = 32'(len); job_tid = tid;
    cfg_hdr_cnt = HCNT_W'(hcnt); cfg_trl_cnt = TCNT_W'(tcnt);
    ob_tready = 1'b1; pl_tvalid = 1'b0;
    cyc = 0; pl_ptr = 0; acc = 0; busy_cyc = -1; first_v = -1; err_n = 0; inj_st = 0;
    finished = 0; stalled = 0; prev = '0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      job_start = 1'b0; cfg_we = 1'b0;
      if (inj_rst && pl_ptr >= 1) begin
        rst_n = 1'b0; pl_tvalid = 1'b0;
        #1;
        chk("rst_ob_tvalid", BW'(ob_tvalid), BW'(0));
        chk("rst_ob_tdata", BW'(ob_tdata), BW'(0));
        chk("rst_pl_tready", BW'(pl_tready), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_byte_cnt", BW'(byte_cnt), BW'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (inj_err && pl_ptr >= 1 && inj_st < 4) begin
        if (inj_st == 0) begin
          job_start = 1'b1; job_len = 32'd5; job_tid = ~tid;
        end
        if (inj_st == 2) begin
          cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = '0;
          cfg_data = ~hdr_d[0]; cfg_user = 8'hee; cfg_strb = 8'h00; cfg_last = 1'b1;
        end
        inj_st++;
      end
      ob_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      pl_tvalid = (pl_ptr < nbeats) && (gap_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      pl_tdata  = (pl_ptr < nbeats) ? pl_data[pl_ptr] : '0;
      #1;
      cur = {ob_tdata, ob_tstrb, ob_tuser, ob_tlast, ob_tid};
      if (cyc == 1) chk("busy_rise", BW'(busy), BW'(1));
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (ob_tvalid && first_v < 0) first_v = cyc;
      if (stalled) begin
        chk("stall_valid", BW'(ob_tvalid), BW'(1));
        chk("stall_hold", cur, prev);
      end
      if (pl_tready) chk("pl_rdy_phase", BW'((acc + int'(ob_tvalid)) >= hc), BW'(1));
      if (pl_ptr >= nbeats) chk("pl_rdy_idle", BW'(pl_tready), BW'(0));
      if (err) err_n++;
      if (done) begin
        chk("done_empty", BW'(exp_q.size()), BW'(0));
        chk("done_busy", BW'(busy), BW'(0));
        chk("byte_cnt", BW'(byte_cnt), BW'(len));
        if (hc == 0 && tc == 0 && len == 0) chk("done_lat", BW'(cyc - busy_cyc), BW'(1));
        finished = 1;
      end
      if (ob_tvalid && ob_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", BW'(1), BW'(0));
        else chk("beat", cur, exp_q.pop_front());
        acc++;
      end
      if (pl_tvalid && pl_tready) pl_ptr++;
      stalled = ob_tvalid && !ob_tready;
      prev = cur;
    end
    if (!finished) chk("timeout", BW'(0), BW'(1));
    if (hc > 0) chk("first_lat", BW'(first_v), BW'(2));
    chk("err_cnt", BW'(err_n), BW'(inj_err ? 2 : 0));
    @(negedge clk);
    ob_tready = 1'b1; pl_tvalid = 1'b0;
    #1;
    chk("done_pulse", BW'(done), BW'(0));
    chk("idle_valid", BW'(ob_tvalid), BW'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_user = '0;
    cfg_strb = '0; cfg_last = 1'b0; cfg_hdr_cnt = '0; cfg_trl_cnt = '0;
    job_start = 1'b0; job_len = '0; job_tid = '0;
    pl_tvalid = 1'b0; pl_tdata = '0; ob_tready = 1'b0;
    clear_model();
    #12;
    chk("reset_ob_tvalid", BW'(ob_tvalid), BW'(0));
    chk("reset_ob_bus", {ob_tdata, ob_tstrb, ob_tuser, ob_tlast, ob_tid}, BW'(0));
    chk("reset_pl_tready", BW'(pl_tready), BW'(0));
    chk("reset_status", BW'({busy, done, err}), BW'(0));
    chk("reset_byte_cnt", BW'(byte_cnt), BW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_tables();
    run_job(20, 1'b1, 7, 2, 0, 0, 0, 0);   // 7 hdr + 3 payload + 2 trl
    run_job(20, 1'b0, 7, 2, 1, 0, 0, 0);   // same job, random back-pressure
    run_job(8,  1'b1, 0, 0, 0, 0, 0, 0);   // single full beat
    run_job(0,  1'b0, 0, 0, 0, 0, 0, 0);   // empty job
    run_job(64, 1'b1, 3, 2, 1, 0, 1, 0);   // rejected start/write mid-payload
    run_job(20, 1'b1, 7, 2, 0, 0, 0, 0);   // tables unaffected by rejected write
    run_job(37, 1'b0, 2, 1, 0, 1, 0, 0);   // payload gaps
    run_job(0,  1'b1, 4, 3, 1, 0, 0, 0);   // header straight into trailer
    for (int k = 0; k < 12; k++)
      run_job($urandom_range(0, 70), 1'($urandom_range(0, 1)), $urandom_range(0, 8),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    run_job(40, 1'b1, 2, 1, 0, 0, 0, 1);   // reset during payload
    run_job(10, 1'b0, 2, 1, 0, 0, 0, 0);   // tables read back as cleared
    load_tables();
    run_job(20, 1'b1, 7, 2, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_axis_job_framer.md
# cr_axis_job_framer

Synthesizable, parametrised AXI-Stream job framer for the CCE engine inbound path. Emits a programmable header sequence, a length-bounded payload stream with generated byte strobes and SoT/EoT tagging, then a programmable trailer sequence, per job. It sits between a host/DMA payload source and the engine `ib_*` port. Data width, header/trailer depth and TID width are parameters.

## Interface
- `DATA_W`, 64, payload/output data width in bits (multiple of 8)
- `STRB_W`, DATA_W/8, bytes per beat
- `USER_W`, 8, tuser width
- `TID_W`, 1, tid width
- `HDR_DEPTH`, 8, max header entries
- `TRL_DEPTH`, 4, max trailer entries

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cfg_we`  in  1  table write strobe
- `cfg_sel`  in  1  0 = header table, 1 = trailer table
- `cfg_idx`  in  $clog2(max(HDR_DEPTH,TRL_DEPTH))  entry index
- `cfg_data`  in  DATA_W  entry tdata
- `cfg_user`  in  USER_W  entry tuser
- `cfg_strb`  in  STRB_W  entry tstrb
- `cfg_last`  in  1  entry tlast
- `cfg_hdr_cnt`  in  $clog2(HDR_DEPTH+1)  header entries used per job
- `cfg_trl_cnt`  in  $clog2(TRL_DEPTH+1)  trailer entries used per job
- `job_start`  in  1  start pulse
- `job_len`  in  32  payload length in bytes
- `job_tid`  in  TID_W  tid for all beats of the job
- `pl_tvalid`/`pl_tready`  in/out  1  payload handshake
- `pl_tdata`  in  DATA_W  payload bytes, LSB-first
- `ob_tvalid`/`ob_tready`  out/in  1  output handshake
- `ob_tdata`  out  DATA_W; `ob_tstrb`  out  STRB_W; `ob_tuser`  out  USER_W; `ob_tlast`  out  1; `ob_tid`  out  TID_W
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle pulse at job completion
- `err`  out  1  one-cycle pulse: rejected job_start or cfg_we while busy
- `byte_cnt`  out  32  payload bytes emitted in current/last job

## Operation
- FSM: IDLE, HDR, PAY, TRL, FIN.
- IDLE: `job_start` latches `job_len`, `job_tid`, `cfg_hdr_cnt`, `cfg_trl_cnt`; clears `byte_cnt`; enters the first non-empty phase in order HDR, PAY, TRL; all empty → FIN.
- HDR/TRL: entries 0..cnt-1 emitted in order with stored data/user/strb/last; `ob_tid` = latched tid.
- PAY: `rem` starts at `job_len`; per accepted beat n = min(rem, STRB_W); `ob_tstrb` = (1<<n)-1; `ob_tuser` = 2 (EoT) when rem ≤ STRB_W, else 0; `ob_tlast` = 0; `ob_tdata` = `pl_tdata` unmodified; rem -= n; `byte_cnt` += n.
- `pl_tready` = (state==PAY) && (!ob_tvalid || ob_tready); never high outside PAY.
- FIN: `done` high one cycle, `busy` low, back to IDLE.
- `cfg_we` in IDLE writes the entry; while busy it is ignored and `err` pulses. `cfg_idx` ≥ depth ignored, no error.
- `job_start` while busy: ignored, `err` pulses.

## Timing
- Reset: state IDLE, all `ob_*` 0, `pl_tready` 0, `busy` 0, `done` 0, `err` 0, `byte_cnt` 0; table contents 0.
- Single registered output stage; it loads when `!ob_tvalid || ob_tready`; `ob_*` stable while `ob_tvalid && !ob_tready`.
- `job_start` sampled at edge E: first beat (header, or payload if `pl_tvalid`) valid after edge E+1; `busy` high after E.
- Full throughput: one beat per cycle under continuous `ob_tready`/`pl_tvalid`, including across phase boundaries.
- `done` asserted after the edge at which the final beat's handshake completes; `busy` falls on the same edge.
- Zero-length job with zero header/trailer: `done` one cycle after `busy` rises; no beats.
- `job_len` not multiple of STRB_W: only the final payload beat is partial.
- Reset mid-job: abandons the job immediately; no `done`; table cleared.

## Structure
- Package `cr_axis_framer_pkg`: tuser codes TUSER_MID=0, SOT=1, EOT=2, SOT_EOT=3; FSM state enum; entry struct {data, user, strb, last}.
- Sub-module `cr_axis_framer_tbl`: parametrised register file (depth, width), one write port, one combinational read port; instantiated twice (header, trailer).

## Test plan
- 7 header entries (SoT-tagged), `job_len`=20, 2 trailer entries (last with `cfg_last`=1) → 12 beats; payload strb ff,ff,0f, tuser 0,0,2; `byte_cnt`=20; `done` once.
- Same job with `ob_tready` toggling 1-0-0-1 random → identical beat sequence, no drop/duplicate, `ob_*` stable when stalled.
- `cfg_hdr_cnt`=0, `cfg_trl_cnt`=0, `job_len`=8 → single beat strb ff tuser 2; `job_len`=0 → no beats, `done` one cycle after `busy`.
- `job_start` and `cfg_we` during PAY → `err` pulses twice, table and job unaffected.
- `pl_tvalid` gaps mid-payload → `ob_tvalid` drops, resumes; `pl_tready` 0 in HDR/TRL.
- Assert `rst_n`=0 in PAY → all outputs 0 asynchronously; next job after reset runs clean.
